// File: rtl/alu_simd.sv
// alu_simd: registered 64-bit SIMD integer ALU over 8/16/32/64-bit lanes.
// Element 0 occupies the most-significant bits; carries and borrows stay inside a lane.
module alu_simd (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:63] oprA,
    input  logic [0:63] oprB,
    input  logic [0:4]  shift_amount,
    input  logic [0:5]  op,
    input  logic [0:1]  ww,
    output logic [0:63] result
);
    logic [63:0] w_a, w_b, w_next, r_result;
    logic [5:0]  w_sh;
    logic [63:0] w_lane [4];
    logic [63:0] w_pair [4];

    assign w_a  = oprA;
    assign w_b  = oprB;
    assign w_sh = {1'b0, shift_amount};

    genvar g, e, k;
    for (g = 0; g < 4; g++) begin : g_w
        localparam int W = 8 << g;
        localparam int N = 64 / W;
        localparam int L = $clog2(W);
        for (e = 0; e < N; e++) begin : g_e
            localparam int H = 63 - e * W;
            logic [W-1:0]   w_x, w_y, w_sra, w_srai, w_el;
            logic [L-1:0]   w_c, w_i;
            logic [W/2-1:0] w_rt, w_t;
            assign w_x    = w_a[H -: W];
            assign w_y    = w_b[H -: W];
            assign w_c    = w_y[L-1:0];
            assign w_i    = w_sh[L-1:0];
            assign w_sra  = $signed(w_x) >>> w_c;
            assign w_srai = $signed(w_x) >>> w_i;
            // Bit-serial floor square root, MSB of the root first.
            always_comb begin
                w_rt = '0;
                w_t  = '0;
                for (int j = W / 2 - 1; j >= 0; j--) begin
                    w_t = w_rt | ((W/2)'(1) << j);
                    if (W'(w_t) * W'(w_t) <= w_x) w_rt = w_t;
                end
            end
            always_comb begin
                case (op)
                    6'd6:    w_el = w_x + w_y;
                    6'd7:    w_el = w_x - w_y;
                    6'd10:   w_el = w_x << w_c;
                    6'd11:   w_el = w_x >> w_c;
                    6'd12:   w_el = w_sra;
                    6'd13:   w_el = {w_x[W/2-1:0], w_x[W-1:W/2]};
                    6'd14:   w_el = (w_y == '0) ? '1 : w_x / w_y;
                    6'd15:   w_el = (w_y == '0) ? w_x : w_x % w_y;
                    6'd18:   w_el = W'(w_rt);
                    6'd19:   w_el = w_x << w_i;
                    6'd20:   w_el = w_x >> w_i;
                    6'd21:   w_el = w_srai;
                    default: w_el = '0;
                endcase
            end
            assign w_lane[g][H -: W] = w_el;
        end
        if (g < 3) begin : g_m
            // Each even/odd pair produces one double-width product in its own slot.
            for (k = 0; k < N / 2; k++) begin : g_p
                localparam int H = 63 - 2 * k * W;
                logic [W-1:0]   w_ae, w_ao, w_be, w_bo;
                logic [2*W-1:0] w_p;
                assign w_ae = w_a[H -: W];
                assign w_ao = w_a[H-W -: W];
                assign w_be = w_b[H -: W];
                assign w_bo = w_b[H-W -: W];
                assign w_p  = (op == 6'd8)  ? (2*W)'(w_ae) * (2*W)'(w_be) :
                              (op == 6'd9)  ? (2*W)'(w_ao) * (2*W)'(w_bo) :
                              (op == 6'd16) ? (2*W)'(w_ae) * (2*W)'(w_ae) :
                              (op == 6'd17) ? (2*W)'(w_ao) * (2*W)'(w_ao) : '0;
                assign w_pair[g][H -: 2*W] = w_p;
            end
        end else begin : g_z
            assign w_pair[g] = '0;
        end
    end

    always_comb begin
        case (op)
            6'd1:                     w_next = w_a & w_b;
            6'd2:                     w_next = w_a | w_b;
            6'd3:                     w_next = w_a ^ w_b;
            6'd4:                     w_next = ~w_a;
            6'd5:                     w_next = w_a;
            6'd8, 6'd9, 6'd16, 6'd17: w_next = w_pair[ww];
            default:                  w_next = w_lane[ww];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_result <= '0;
        else        r_result <= w_next;
    end

    assign result = r_result;
endmodule

// File: tb/tb_alu_simd.sv
// tb_alu_simd: directed vectors for alu_simd followed by a back-to-back op x width sweep
// against an independent element-by-element reference model.
module tb_alu_simd;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] oprA = '0, oprB = '0;
    logic [4:0]  shift_amount = '0;
    logic [5:0]  op = '0;
    logic [1:0]  ww = '0;
    logic [63:0] result;
    int          checks = 0;
    int          errors = 0;

    alu_simd dut (
        .clk(clk), .reset(reset), .oprA(oprA), .oprB(oprB),
        .shift_amount(shift_amount), .op(op), .ww(ww), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic vec(input string tag, input logic [5:0] o, input logic [1:0] w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] sa,
                       input logic [63:0] exp);
        @(negedge clk);
        op = o; ww = w; oprA = a; oprB = b; shift_amount = sa;
        @(negedge clk);
        check(tag, result, exp);
    endtask

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [4:0] sa, input int o, input int w);
        int          wd, n, c, i;
        logic [63:0] m, x, y, r, res, lo, hi, mid;
        wd  = 8 << w;
        n   = 64 / wd;
        m   = (wd == 64) ? '1 : (64'd1 << wd) - 64'd1;
        res = '0;
        case (o)
            1: return a & b;
            2: return a | b;
            3: return a ^ b;
            4: return ~a;
            5: return a;
            8, 9, 16, 17: begin
                if (wd == 64) return '0;
                for (int s = 0; s < n / 2; s++) begin
                    i = 2 * s + ((o == 9 || o == 17) ? 1 : 0);
                    x = (a >> (64 - (i + 1) * wd)) & m;
                    y = (o >= 16) ? x : (b >> (64 - (i + 1) * wd)) & m;
                    res |= (x * y) << (64 - (s + 1) * 2 * wd);
                end
                return res;
            end
            default: ;
        endcase
        for (int el = 0; el < n; el++) begin
            x = (a >> (64 - (el + 1) * wd)) & m;
            y = (b >> (64 - (el + 1) * wd)) & m;
            c = (o >= 19) ? int'(sa) % wd : int'(y[5:0]) % wd;
            case (o)
                6:       r = x + y;
                7:       r = x - y;
                10, 19:  r = x << c;
                11, 20:  r = x >> c;
                12, 21:  r = (x >> c) | (((x >> (wd - 1)) != 0) ? (m & ~(m >> c)) : 64'd0);
                13:      r = (x << (wd / 2)) | (x >> (wd / 2));
                14:      r = (y == 0) ? m : x / y;
                15:      r = (y == 0) ? x : x % y;
                18: begin
                    lo = 0;
                    hi = (wd == 64) ? 64'hFFFF_FFFF : (64'd1 << (wd / 2)) - 64'd1;
                    while (lo < hi) begin
                        mid = (lo + hi + 1) >> 1;
                        if (mid * mid <= x) lo = mid;
                        else hi = mid - 64'd1;
                    end
                    r = lo;
                end
                default: r = 0;
            endcase
            res |= (r & m) << (64 - (el + 1) * wd);
        end
        return res;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp_q, a, b;
        string       tag_q;
        bit          pend;
        op = 6'd6; oprA = 64'h00FF_00FF_00FF_00FF; oprB = 64'h0101_0101_0101_0101;
        repeat (2) @(negedge clk);
        check("reset_hold", result, 64'h0);
        reset = 1'b1;

        vec("add_b",   6, 0, 64'h00FF_00FF_00FF_00FF, 64'h0101_0101_0101_0101, 0, 64'h0100_0100_0100_0100);
        vec("add_h",   6, 1, 64'h00FF_00FF_00FF_00FF, 64'h0101_0101_0101_0101, 0, 64'h0200_0200_0200_0200);
        vec("sub_b",   7, 0, 64'h0100_0100_0100_0100, 64'h0101_0101_0101_0101, 0, 64'h00FF_00FF_00FF_00FF);
        vec("sub_h",   7, 1, 64'h0100_0100_0100_0100, 64'h0101_0101_0101_0101, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        vec("sll_d",  10, 3, 64'h8080_8080_8080_8080, 64'h0101_0101_0101_0101, 0, 64'h0101_0101_0101_0100);
        vec("sll_b",  10, 0, 64'h8080_8080_8080_8080, 64'h0101_0101_0101_0101, 0, 64'h0);
        vec("sra_b",  12, 0, 64'h8080_8080_8080_8080, 64'h0101_0101_0101_0101, 0, 64'hC0C0_C0C0_C0C0_C0C0);
        vec("srli_b", 20, 0, 64'h8080_8080_8080_8080, 64'h0101_0101_0101_0101, 4, 64'h0808_0808_0808_0808);
        vec("srli_bw",20, 0, 64'h8080_8080_8080_8080, 64'h0, 5'd12, 64'h0808_0808_0808_0808);
        vec("muleu",   8, 0, 64'h8080_8080_8080_8080, 64'h0101_0101_0101_0101, 0, 64'h0080_0080_0080_0080);
        vec("mulou",   9, 0, 64'h8080_8080_8080_8080, 64'h0101_0101_0101_0101, 0, 64'h0080_0080_0080_0080);
        vec("sqeu",   16, 0, 64'h8080_8080_8080_8080, 64'h0101_0101_0101_0101, 0, 64'h4000_4000_4000_4000);
        vec("muleu_d", 8, 3, 64'h8080_8080_8080_8080, 64'h0101_0101_0101_0101, 0, 64'h0);
        vec("rtth_b", 13, 0, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, 64'h2143_6587_A9CB_ED0F);
        vec("rtth_h", 13, 1, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, 64'h3412_7856_BC9A_F0DE);
        vec("rtth_w", 13, 2, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, 64'h5678_1234_DEF0_9ABC);
        vec("rtth_d", 13, 3, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, 64'h9ABC_DEF0_1234_5678);
        vec("not",     4, 2, 64'h1234_5678_9ABC_DEF0, 64'h0, 0, 64'hEDCB_A987_6543_210F);
        vec("div",    14, 0, 64'h0A0A_0A0A_0A0A_0A0A, 64'h0303_0303_0303_0303, 0, 64'h0303_0303_0303_0303);
        vec("mod",    15, 0, 64'h0A0A_0A0A_0A0A_0A0A, 64'h0303_0303_0303_0303, 0, 64'h0101_0101_0101_0101);
        vec("div0",   14, 0, 64'h0A0A_0A0A_0A0A_0A0A, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        vec("mod0",   15, 0, 64'h0A0A_0A0A_0A0A_0A0A, 64'h0, 0, 64'h0A0A_0A0A_0A0A_0A0A);
        vec("sqrt",   18, 0, 64'h5151_5151_5151_5151, 64'h0, 0, 64'h0909_0909_0909_0909);
        vec("nop",     0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0);
        vec("op22",   22, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0);
        vec("op63",   63, 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0);

        // Asynchronous reset mid-stream, then recovery on the first edge.
        vec("mov",     5, 0, 64'hDEAD_BEEF_0123_4567, 64'h0, 0, 64'hDEAD_BEEF_0123_4567);
        #2 reset = 1'b0;
        #1 check("reset_async", result, 64'h0);
        @(negedge clk);
        check("reset_edge", result, 64'h0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_release", result, 64'hDEAD_BEEF_0123_4567);

        pend = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 4; w++) begin
                for (int o = 0; o < 22; o++) begin
                    @(negedge clk);
                    if (pend) check(tag_q, result, exp_q);
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    if (r == 1) b &= 64'hFFFF_0000_FF00_00FF;
                    op = 6'(o); ww = 2'(w); oprA = a; oprB = b;
                    shift_amount = 5'($urandom_range(0, 31));
                    exp_q = model(a, b, shift_amount, o, w);
                    tag_q = $sformatf("sweep op%0d ww%0d", o, w);
                    pend  = 1'b1;
                end
            end
        end
        @(negedge clk);
        check(tag_q, result, exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_simd.md
Name: alu_simd

Overview:
- Registered 64-bit SIMD integer ALU for the NoC processor datapath.
- Operates on packed elements of 8, 16, 32 or 64 bits, selected by `ww`.
- Bit numbering is big-endian: bit 0 is the MSB. Element 0 occupies the most-significant bits.
- One-cycle latency; sits between register-file read and writeback.

Parameters:
- None. Widths are fixed.

Ports:
- `clk` · in · 1 · rising-edge clock
- `reset` · in · 1 · asynchronous, active-low reset
- `oprA` · in · 64 [0:63] · operand A (rA)
- `oprB` · in · 64 [0:63] · operand B (rB); also supplies per-element shift counts
- `shift_amount` · in · 5 [0:4] · immediate shift count for ops 19–21
- `op` · in · 6 [0:5] · operation select
- `ww` · in · 2 [0:1] · element width: 00 = byte, 01 = halfword, 10 = word, 11 = doubleword
- `result` · out · 64 [0:63] · registered result

Behaviour:
- `reset` low clears `result` to 0 immediately, independent of `clk`; `result` holds 0 while `reset` is low.
- On each rising edge with `reset` high, `result` <= f(`oprA`, `oprB`, `shift_amount`, `op`, `ww`) from inputs sampled at that edge. Latency is 1 cycle, with a new op accepted every cycle.
- All arithmetic is per element and unsigned unless stated; carries and borrows never cross element boundaries.
- Element width W = 8 << `ww`. Per-element shift count = low log2(W) bits of the matching `oprB` element.
- Op map:
  - 0: NOP, result = 0
  - 1: AND
  - 2: OR
  - 3: XOR
  - 4: NOT A
  - 5: MOV A
  - 6: ADD, modulo 2^W
  - 7: SUB (A − B), modulo 2^W
  - 8: MULEU
  - 9: MULOU
  - 10: SLL by per-element count
  - 11: SRL by per-element count
  - 12: SRA by per-element count, sign bit = element MSB
  - 13: RTTH, swap upper and lower halves of each element
  - 14: DIV, unsigned quotient
  - 15: MOD, unsigned remainder
  - 16: SQEU
  - 17: SQOU
  - 18: SQRT, floor of unsigned square root per element
  - 19: SLLI
  - 20: SRLI
  - 21: SRAI
- Ops 1–5 ignore `ww`.
- MULEU/MULOU: multiply the even (0,2,4,…) or odd (1,3,5,…) W-bit elements of A and B. Each 2W-bit product fills the 2W-bit slot that contains the source pair.
- SQEU/SQOU: same slot rules as MULEU/MULOU, but squaring A only.
- For ops 8, 9, 16, 17 with `ww` = 11, result = 0.
- Divide by zero: DIV element = all ones; MOD element = dividend.
- RTTH with `ww` = 00 swaps the two nibbles of each byte.
- Immediate shifts (ops 19–21): count = `shift_amount` mod W, applied to every element. For `ww` = 11 the count is zero-extended to 6 bits.
- `op` values 22–63 give result = 0.
- X-free: every defined op/ww combination produces a defined value; no latches.

Test Plan:
- Reset: drive `reset` low mid-stream with valid ops → `result` = 0 with no clock edge; release `reset` → first edge loads the op result.
- Lane isolation: A=0x00FF00FF00FF00FF, B=0x0101010101010101, ADD:
  - `ww`=00 → 0x0100010001000100
  - `ww`=01 → 0x0200020002000200
- Shifts: A=0x8080808080808080, B=0x0101010101010101:
  - SLL `ww`=11 → 0x0101010101010100
  - SLL `ww`=00 → 0
  - SRA `ww`=00 → 0xC0C0C0C0C0C0C0C0
  - SRLI `ww`=00 with `shift_amount`=4 → 0x0808080808080808
- Multiply/square: same A and B, `ww`=00:
  - MULEU → 0x0080008000800080
  - MULOU → 0x0080008000800080
  - SQEU → 0x4000400040004000
  - MULEU `ww`=11 → 0
- RTTH/logic: A=0x123456789ABCDEF0:
  - RTTH `ww`=01 → 0x34127856BC9AF0DE
  - RTTH `ww`=10 → 0x56781234DEF09ABC
  - NOT → 0xEDCBA9876543210F
- Div/mod/sqrt, `ww`=00:
  - A=0x0A…0A, B=0x03…03: DIV → 0x0303…03; MOD → 0x0101…01
  - B=0: DIV → 0xFF…FF; MOD → A
  - A=0x51…51: SQRT → 0x0909…09
- Sweep: op 0–21 × `ww` 0–3 every cycle against a reference model, back-to-back with no bubbles.
